// File: rtl/hazard_controller.sv
// Pipeline sequencing for the 5-stage core: load-use and ID-branch operand stalls,
// cache freezes, IF/ID flush on taken transfers, stall-class state and saturating counters.
module hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             use_rs2,
    input  logic             jalr,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_regwrite,
    input  logic             ID_EX_memread,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_memread,
    input  logic             ICACHE_stall,
    input  logic             DCACHE_stall,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             pipe_write,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_hz_cnt,
    output logic [CNT_W-1:0] stall_mem_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HAZ    = 2'b01,
        FREEZE = 2'b10
    } hz_state_t;

    hz_state_t state_reg, state_next;

    logic ex_rs1_match, ex_rs2_match, mem_rs1_match, mem_rs2_match;
    logic load_use, br_hz, hazard, freeze;

    // x0 never carries a dependency; rs2 only counts when the instruction reads it
    assign ex_rs1_match  = (ID_EX_rd != 5'd0) && (ID_EX_rd == IF_ID_rs1);
    assign ex_rs2_match  = use_rs2 && (ID_EX_rd != 5'd0) && (ID_EX_rd == IF_ID_rs2);
    assign mem_rs1_match = (EX_MEM_rd != 5'd0) && (EX_MEM_rd == IF_ID_rs1);
    assign mem_rs2_match = use_rs2 && (EX_MEM_rd != 5'd0) && (EX_MEM_rd == IF_ID_rs2);

    assign load_use = ID_EX_memread && (ex_rs1_match || ex_rs2_match);
    assign br_hz    = (jalr || branch) &&
                      ((ID_EX_regwrite && ex_rs1_match) ||
                       (EX_MEM_memread && mem_rs1_match) ||
                       (branch && ((ID_EX_regwrite && ex_rs2_match) ||
                                   (EX_MEM_memread && mem_rs2_match))));
    assign hazard   = load_use || br_hz;
    assign freeze   = ICACHE_stall || DCACHE_stall;

    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        pipe_write   = 1'b1;
        if (rst) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_write  = 1'b0;
            IF_ID_flush = 1'b1;
        end else if (freeze) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_write  = 1'b0;
        end else if (hazard) begin
            // a taken branch waits here until its operands are safe
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
        end
    end

    always_comb begin
        state_next = RUN;
        if (freeze)
            state_next = FREEZE;
        else if (hazard)
            state_next = HAZ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    assign hz_state = state_reg;

    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc[0] = hazard && !freeze;
    assign cnt_inc[1] = freeze;
    assign cnt_inc[2] = IF_ID_flush && !rst;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    cnt_reg <= '0;
                else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign stall_hz_cnt  = cnt_val[0];
    assign stall_mem_cnt = cnt_val[1];
    assign flush_cnt     = cnt_val[2];

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a table of combinational vectors plus
// hand-written multi-cycle sequences for stalls, freezes, saturation and reset.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_rd = '0, EX_MEM_rd = '0;
    logic        use_rs2 = 0, jalr = 0, branch = 0, branch_taken = 0;
    logic        ID_EX_regwrite = 0, ID_EX_memread = 0, EX_MEM_memread = 0;
    logic        ICACHE_stall = 0, DCACHE_stall = 0;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write;
    logic [1:0]  hz_state, hz_state_s;
    logic [31:0] stall_hz_cnt, stall_mem_cnt, flush_cnt;
    logic        pcw_s, ifw_s, fl_s, bub_s, pw_s;
    logic [3:0]  stall_hz_s, stall_mem_s, flush_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .use_rs2(use_rs2), .jalr(jalr), .branch(branch), .branch_taken(branch_taken),
        .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
        .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .pipe_write(pipe_write), .hz_state(hz_state),
        .stall_hz_cnt(stall_hz_cnt), .stall_mem_cnt(stall_mem_cnt), .flush_cnt(flush_cnt)
    );

    hazard_controller #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .use_rs2(use_rs2), .jalr(jalr), .branch(branch), .branch_taken(branch_taken),
        .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite), .ID_EX_memread(ID_EX_memread),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
        .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall),
        .PC_write(pcw_s), .IF_ID_write(ifw_s), .IF_ID_flush(fl_s),
        .ID_EX_bubble(bub_s), .pipe_write(pw_s), .hz_state(hz_state_s),
        .stall_hz_cnt(stall_hz_s), .stall_mem_cnt(stall_mem_s), .flush_cnt(flush_s)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u2, jr, br, tk;
        logic [4:0] exrd;
        logic       exrw, exmr;
        logic [4:0] memrd;
        logic       memmr, ic, dc;
        logic [4:0] exp;   // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write}
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IF_ID_rs1 = 0; IF_ID_rs2 = 0; use_rs2 = 0; jalr = 0; branch = 0; branch_taken = 0;
        ID_EX_rd = 0; ID_EX_regwrite = 0; ID_EX_memread = 0; EX_MEM_rd = 0; EX_MEM_memread = 0;
        ICACHE_stall = 0; DCACHE_stall = 0;
    endtask

    task automatic apply(input vec_t v);
        IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2; use_rs2 = v.u2; jalr = v.jr; branch = v.br;
        branch_taken = v.tk; ID_EX_rd = v.exrd; ID_EX_regwrite = v.exrw; ID_EX_memread = v.exmr;
        EX_MEM_rd = v.memrd; EX_MEM_memread = v.memmr; ICACHE_stall = v.ic; DCACHE_stall = v.dc;
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_write};
    endfunction

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        //          name            rs1 rs2 u2 jr br tk exrd rw mr memrd mm ic dc  exp
        vecs[0]  = '{"idle",         0,  0, 0, 0, 0, 0,  0,  0, 0,  0,   0, 0, 0, 5'b11001};
        vecs[1]  = '{"load_use_rs2", 3,  5, 1, 0, 0, 0,  5,  1, 1,  0,   0, 0, 0, 5'b00011};
        vecs[2]  = '{"rs2_unused",   3,  5, 0, 0, 0, 0,  5,  1, 1,  0,   0, 0, 0, 5'b11001};
        vecs[3]  = '{"rd_zero",      0,  0, 1, 0, 0, 0,  0,  1, 1,  0,   0, 0, 0, 5'b11001};
        vecs[4]  = '{"jalr_alu",     1,  0, 0, 1, 0, 0,  1,  1, 0,  0,   0, 0, 0, 5'b00011};
        vecs[5]  = '{"br_mem_load",  7,  0, 1, 0, 1, 0,  0,  0, 0,  7,   1, 0, 0, 5'b00011};
        vecs[6]  = '{"jalr_no_rs2",  3,  7, 1, 1, 0, 0,  7,  1, 0,  0,   0, 0, 0, 5'b11001};
        vecs[7]  = '{"br_rs2_alu",   3,  9, 1, 0, 1, 0,  9,  1, 0,  0,   0, 0, 0, 5'b00011};
        vecs[8]  = '{"taken",        4,  6, 1, 0, 1, 1,  8,  1, 0,  2,   1, 0, 0, 5'b11101};
        vecs[9]  = '{"haz_over_tk",  1,  0, 0, 1, 0, 1,  1,  1, 0,  0,   0, 0, 0, 5'b00011};
        vecs[10] = '{"icache_frz",   1,  0, 0, 1, 0, 1,  1,  1, 0,  0,   0, 1, 0, 5'b00000};
        vecs[11] = '{"dcache_frz",   0,  0, 0, 0, 0, 1,  0,  0, 0,  0,   0, 0, 1, 5'b00000};
        vecs[12] = '{"alu_no_br",    5,  0, 0, 0, 0, 0,  5,  1, 0,  0,   0, 0, 0, 5'b11001};
        vecs[13] = '{"mem_ld_no_br", 5,  0, 0, 0, 0, 0,  0,  0, 0,  5,   1, 0, 0, 5'b11001};

        // reset state while rst is held
        step();
        check("rst_outputs", outs(), 32'b00100);
        check("rst_state", {30'd0, hz_state}, 32'd0);
        check("rst_stall_hz", stall_hz_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            #1;
            check(vecs[i].name, outs(), {27'd0, vecs[i].exp});
            step();
        end

        // load-use: one bubble, then HAZ state and one counted cycle
        do_reset();
        apply(vecs[1]);
        #1;
        check("lu_bubble", outs(), 32'b00011);
        step();
        idle();
        #1;
        check("lu_state", {30'd0, hz_state}, 32'd1);
        check("lu_cnt", stall_hz_cnt, 32'd1);
        check("lu_resume", outs(), 32'b11001);

        // lw x7 ; beq x7,x0 : two bubbles, then taken flush
        do_reset();
        branch = 1; use_rs2 = 1; IF_ID_rs1 = 7; ID_EX_rd = 7; ID_EX_regwrite = 1; ID_EX_memread = 1;
        #1;
        check("lwbr_c1", outs(), 32'b00011);
        step();
        ID_EX_rd = 0; ID_EX_regwrite = 0; ID_EX_memread = 0; EX_MEM_rd = 7; EX_MEM_memread = 1;
        #1;
        check("lwbr_c2", outs(), 32'b00011);
        check("lwbr_c2_state", {30'd0, hz_state}, 32'd1);
        step();
        EX_MEM_rd = 0; EX_MEM_memread = 0; branch_taken = 1;
        #1;
        check("lwbr_c3", outs(), 32'b11101);
        step();
        idle();
        #1;
        check("lwbr_hz_cnt", stall_hz_cnt, 32'd2);
        check("lwbr_flush_cnt", flush_cnt, 32'd1);
        check("lwbr_state", {30'd0, hz_state}, 32'd0);

        // D-cache freeze held 5 cycles over a load-use hazard
        do_reset();
        apply(vecs[1]);
        DCACHE_stall = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("frz_c%0d", i), outs(), 32'b00000);
            step();
        end
        check("frz_mem_cnt", stall_mem_cnt, 32'd5);
        check("frz_hz_cnt", stall_hz_cnt, 32'd0);
        check("frz_state", {30'd0, hz_state}, 32'd2);
        DCACHE_stall = 0;
        #1;
        check("frz_release", outs(), 32'b00011);
        step();
        idle();
        #1;
        check("frz_after_hz", stall_hz_cnt, 32'd1);
        check("frz_after_state", {30'd0, hz_state}, 32'd1);
        check("frz_after_mem", stall_mem_cnt, 32'd5);

        // both caches stalled counts as one freeze per cycle; 4-bit counter saturates
        do_reset();
        ICACHE_stall = 1; DCACHE_stall = 1;
        step();
        check("both_mem_cnt", stall_mem_cnt, 32'd1);
        DCACHE_stall = 0;
        for (int i = 1; i < 20; i++) step();
        check("sat_small", {28'd0, stall_mem_s}, 32'd15);
        check("sat_wide", stall_mem_cnt, 32'd20);

        // asynchronous reset mid-freeze clears state before the next edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", {30'd0, hz_state}, 32'd0);
        check("arst_mem_cnt", stall_mem_cnt, 32'd0);
        check("arst_small_cnt", {28'd0, stall_mem_s}, 32'd0);
        check("arst_outputs", outs(), 32'b00100);
        step();
        rst = 1'b0;
        ICACHE_stall = 0;
        apply(vecs[4]);
        #1;
        check("post_rst_eval", outs(), 32'b00011);
        step();
        check("post_rst_hz", stall_hz_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It pairs with the forwarding logic: forwarding covers every dependency it can, and this block covers the rest. It detects load-use hazards and branch/jalr operand hazards (branches resolve in ID), freezes the pipeline on I-cache/D-cache stalls, and flushes IF/ID on taken control transfers. It also tracks stall causes in a state register and keeps saturating performance counters.

Parameters:
CNT_W, 32, width of each performance counter (saturating)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
IF_ID_rs1  input  5  rs1 of instruction in ID
IF_ID_rs2  input  5  rs2 of instruction in ID
use_rs2  input  1  ID instruction reads rs2 (R/S/B type)
jalr  input  1  ID instruction is JALR
branch  input  1  ID instruction is conditional branch
branch_taken  input  1  ID resolution: control transfer taken (includes JAL/JALR)
ID_EX_rd  input  5  destination in EX
ID_EX_regwrite  input  1  EX instruction writes register
ID_EX_memread  input  1  EX instruction is load
EX_MEM_rd  input  5  destination in MEM
EX_MEM_memread  input  1  MEM instruction is load
ICACHE_stall  input  1  I-cache not ready
DCACHE_stall  input  1  D-cache not ready
PC_write  output  1  PC update enable
IF_ID_write  output  1  IF/ID register enable
IF_ID_flush  output  1  load NOP into IF/ID
ID_EX_bubble  output  1  load NOP (control zeros) into ID/EX
pipe_write  output  1  enable for ID/EX, EX/MEM, MEM/WB registers
hz_state  output  2  00 RUN, 01 HAZ, 10 FREEZE
stall_hz_cnt  output  CNT_W  cycles spent with hazard bubble
stall_mem_cnt  output  CNT_W  cycles spent frozen by caches
flush_cnt  output  CNT_W  number of IF/ID flushes

Behaviour:
- Match terms: a match requires rd != 0. rs2 participates only when use_rs2=1.
- load_use = ID_EX_memread & rd match (ID_EX_rd vs IF_ID_rs1/rs2).
- br_hz = (jalr|branch) & [ (ID_EX_regwrite & ID_EX_rd==IF_ID_rs1) | (EX_MEM_memread & EX_MEM_rd==IF_ID_rs1) | (branch & use_rs2 & same terms on rs2) ].
- hazard = load_use | br_hz. A load feeding a branch therefore stalls 2 cycles; an ALU result feeding a branch stalls 1 cycle.
- freeze = ICACHE_stall | DCACHE_stall. Freeze has priority over every other condition.
- Outputs are combinational from current inputs:
  - freeze: PC_write=0, IF_ID_write=0, pipe_write=0, ID_EX_bubble=0, IF_ID_flush=0. Nothing advances and nothing is lost.
  - else hazard: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, pipe_write=1, IF_ID_flush=0. A taken branch is ignored until its operands are safe.
  - else branch_taken: PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=0, pipe_write=1.
  - else: PC_write=1, IF_ID_write=1, pipe_write=1, all others 0.
- While rst=1, the datapath enables above are forced to 0 and IF_ID_flush=1.
- State register (updated each edge, next = class of current cycle):
  - FREEZE if freeze; HAZ if hazard; else RUN.
  - hz_state reflects the class of the previous cycle. Any state can reach any state directly.
- Counters, each saturating at 2^CNT_W-1 (no wrap):
  - stall_hz_cnt += 1 when hazard & !freeze.
  - stall_mem_cnt += 1 when freeze.
  - flush_cnt += 1 when IF_ID_flush & !rst.
- Reset (asynchronous, immediate): hz_state=RUN, all counters=0. Asserting reset mid-stall aborts the stall. After release, the first cycle is evaluated fresh from the inputs.
- Simultaneous events:
  - ICACHE and DCACHE stall together: one freeze cycle, stall_mem_cnt +1 only.
  - Hazard during freeze: not counted as a hazard cycle; it is re-evaluated when freeze drops.

Test Plan:
- Load x5 in EX, ID add uses rs2=x5, use_rs2=1 -> PC_write=0, IF_ID_write=0, ID_EX_bubble=1 for 1 cycle; next cycle hz_state=01, stall_hz_cnt=1.
- lw x7 then beq x7,x0 -> cycle1 bubble (ID_EX match), cycle2 bubble (EX_MEM load match), cycle3 branch_taken=1 -> IF_ID_flush=1; stall_hz_cnt=2, flush_cnt=1.
- ID_EX_rd=0 with memread, rs1=0 -> no stall; jalr with ID_EX_regwrite and rd=x1=rs1 -> exactly 1 bubble.
- DCACHE_stall held 5 cycles during load-use -> all enables 0, bubble 0, stall_mem_cnt=5, stall_hz_cnt unchanged; after release, 1 bubble.
- CNT_W=4, freeze held 20 cycles -> stall_mem_cnt stops at 15.
- Assert rst asynchronously mid-freeze -> hz_state=00 and counters=0 immediately (before next edge); IF_ID_flush=1 while rst high.
